// File: rtl/spi_sram_ctrl.sv
// spi_sram_ctrl: SPI mode-0 master that turns single CPU load/store requests
// into serial-SRAM READ/WRITE frames, with an optional WRMR after reset.
`timescale 1ns/1ps
module spi_sram_ctrl #(
  parameter int ADDR_W    = 24,
  parameter int CLK_DIV   = 2,
  parameter int INIT_MODE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              busy,
  output logic              sclk,
  output logic              sram_ce,
  output logic              si,
  input  logic              so
);
  // Longest frame: command + address + one word of data, MSB-aligned.
  localparam int FRAME_W = 8 + ADDR_W + 32;
  localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    RESET_INIT = 3'd0,
    IDLE       = 3'd1,
    CS_SETUP   = 3'd2,
    SHIFT      = 3'd3,
    CS_HOLD    = 3'd4,
    DONE       = 3'd5
  } state_t;

  localparam state_t RESET_STATE = (INIT_MODE != 0) ? RESET_INIT : IDLE;

  // Byte 0 goes out first, so the little-endian word is byte-reversed.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Received bytes arrive byte0-first; rebuild a zero-extended LE value.
  function automatic logic [31:0] order_rx(input logic [31:0] rx, input logic [2:0] nb);
    logic [31:0] r;
    case (nb)
      3'd1:    r = {24'h000000, rx[7:0]};
      3'd2:    r = {16'h0000, rx[7:0], rx[15:8]};
      default: r = bswap32(rx);
    endcase
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bits_q, bits_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [31:0]        rx_q, rx_d;
  logic [2:0]         nbytes_q, nbytes_d;
  logic               we_q, we_d;
  logic               init_q, init_d;
  logic               sclk_q, sclk_d;
  logic               ce_q, ce_d;
  logic               si_q, si_d;
  logic               ready_q, ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               busy_q, busy_d;
  logic [2:0]         nb_s;

  // Decode the request size into a byte count (10 and 11 both mean word).
  always_comb begin
    case (req_size)
      2'b00:   nb_s = 3'd1;
      2'b01:   nb_s = 3'd2;
      default: nb_s = 3'd4;
    endcase
  end

  // Next-state and next-output logic; every output is the flop of its _d.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bits_d      = bits_q;
    shreg_d     = shreg_q;
    rx_d        = rx_q;
    nbytes_d    = nbytes_q;
    we_d        = we_q;
    init_d      = init_q;
    sclk_d      = sclk_q;
    ce_d        = ce_q;
    si_d        = si_q;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    case (state_q)
      RESET_INIT: begin
        shreg_d = {16'h0140, {(FRAME_W-16){1'b0}}};
        bits_d  = BIT_W'(16);
        init_d  = 1'b1;
        we_d    = 1'b1;
        cnt_d   = CNT_W'(0);
        state_d = CS_SETUP;
        ce_d    = 1'b0;
        sclk_d  = 1'b0;
        si_d    = shreg_d[FRAME_W-1];
        busy_d  = 1'b1;
      end
      IDLE: begin
        ce_d   = 1'b1;
        sclk_d = 1'b0;
        busy_d = 1'b0;
        if (req_valid && ready_q) begin
          we_d     = req_we;
          nbytes_d = nb_s;
          init_d   = 1'b0;
          shreg_d  = {(req_we ? 8'h02 : 8'h03), req_addr,
                      (req_we ? bswap32(req_wdata) : 32'h00000000)};
          bits_d   = BIT_W'(8 + ADDR_W) + BIT_W'({nb_s, 3'b000});
          cnt_d    = CNT_W'(0);
          state_d  = CS_SETUP;
          ce_d     = 1'b0;
          si_d     = shreg_d[FRAME_W-1];
          busy_d   = 1'b1;
        end else begin
          ready_d  = 1'b1;
        end
      end
      CS_SETUP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = CNT_W'(0);
          state_d = SHIFT;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = CNT_W'(0);
          if (!sclk_q) begin
            // Rising SCLK: SRAM data is sampled on this very clk edge.
            sclk_d = 1'b1;
            rx_d   = {rx_q[30:0], so};
          end else begin
            sclk_d = 1'b0;
            if (bits_q == BIT_W'(1)) begin
              state_d = CS_HOLD;
              si_d    = 1'b0;
            end else begin
              shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
              si_d    = shreg_q[FRAME_W-2];
              bits_d  = bits_q - BIT_W'(1);
            end
          end
        end
      end
      CS_HOLD: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d       = CNT_W'(0);
          state_d     = DONE;
          ce_d        = 1'b1;
          rsp_valid_d = !init_q;
          if (!we_q && !init_q) begin
            rdata_d = order_rx(rx_q, nbytes_q);
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        init_d  = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ce_d    = 1'b1;
        sclk_d  = 1'b0;
        si_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RESET_STATE;
      cnt_q       <= CNT_W'(0);
      bits_q      <= BIT_W'(0);
      shreg_q     <= {FRAME_W{1'b0}};
      rx_q        <= 32'h00000000;
      nbytes_q    <= 3'd0;
      we_q        <= 1'b0;
      init_q      <= 1'b0;
      sclk_q      <= 1'b0;
      ce_q        <= 1'b1;
      si_q        <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h00000000;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bits_q      <= bits_d;
      shreg_q     <= shreg_d;
      rx_q        <= rx_d;
      nbytes_q    <= nbytes_d;
      we_q        <= we_d;
      init_q      <= init_d;
      sclk_q      <= sclk_d;
      ce_q        <= ce_d;
      si_q        <= si_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign busy      = busy_q;
  assign sclk      = sclk_q;
  assign sram_ce   = ce_q;
  assign si        = si_q;

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Directed bench for spi_sram_ctrl: two instances (24-bit/div 2 and
// 16-bit/div 1) share one behavioural serial-SRAM model through a mux.
`timescale 1ns/1ps
module tb_spi_sram_ctrl;
  logic        clk = 1'b0;
  logic        reset_a, reset_b, sel;
  logic        req_valid_a, req_valid_b, req_we;
  logic [1:0]  req_size;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic        ready_a, ready_b, rsp_valid_a, rsp_valid_b, busy_a, busy_b;
  logic [31:0] rdata_a, rdata_b;
  logic        sclk_a, sclk_b, ce_a, ce_b, si_a, si_b;
  logic        m_so, m_sclk, m_ce, m_si;
  int          aw;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  spi_sram_ctrl #(.ADDR_W(24), .CLK_DIV(2), .INIT_MODE(1)) dut_a (
    .clk(clk), .reset(reset_a), .req_valid(req_valid_a), .req_ready(ready_a),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rdata_a), .busy(busy_a), .sclk(sclk_a),
    .sram_ce(ce_a), .si(si_a), .so(m_so));

  spi_sram_ctrl #(.ADDR_W(16), .CLK_DIV(1), .INIT_MODE(1)) dut_b (
    .clk(clk), .reset(reset_b), .req_valid(req_valid_b), .req_ready(ready_b),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr[15:0]), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rdata_b), .busy(busy_b), .sclk(sclk_b),
    .sram_ce(ce_b), .si(si_b), .so(m_so));

  assign m_sclk = sel ? sclk_b : sclk_a;
  assign m_ce   = sel ? ce_b : ce_a;
  assign m_si   = sel ? si_b : si_a;
  assign aw     = sel ? 16 : 24;

  // ---------------- behavioural serial SRAM ----------------
  logic [7:0]  mem [0:65535];
  int          m_bits = 0;
  int          m_rises = 0;
  logic [7:0]  m_cmd, m_byte, m_mode;
  logic [23:0] m_addr;
  logic [15:0] m_frame16;
  int          so_idx;
  logic [7:0]  so_byte;

  // Model input side: shift in SI on each rising SCLK while selected.
  always @(posedge m_sclk or posedge m_ce) begin
    if (m_ce) begin
      m_bits <= 0;
    end else begin
      m_rises   <= m_rises + 1;
      m_bits    <= m_bits + 1;
      m_frame16 <= {m_frame16[14:0], m_si};
      if (m_bits < 8) begin
        m_cmd <= {m_cmd[6:0], m_si};
      end else if (m_cmd == 8'h01) begin
        m_byte <= {m_byte[6:0], m_si};
        if (m_bits == 15) m_mode <= {m_byte[6:0], m_si};
      end else if (m_bits < 8 + aw) begin
        m_addr <= {m_addr[22:0], m_si};
      end else if (m_cmd == 8'h02) begin
        m_byte <= {m_byte[6:0], m_si};
        if ((m_bits - 8 - aw) % 8 == 7)
          mem[m_addr[15:0] + 16'((m_bits - 8 - aw) / 8)] <= {m_byte[6:0], m_si};
      end
    end
  end

  // Model output side: present read data MSB-first after each falling SCLK.
  always @(negedge m_sclk or negedge m_ce) begin
    if (!m_ce && m_cmd == 8'h03 && m_bits >= 8 + aw) begin
      so_idx  = m_bits - 8 - aw;
      so_byte = mem[m_addr[15:0] + 16'(so_idx / 8)];
      m_so <= so_byte[7 - (so_idx % 8)];
    end else begin
      m_so <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic s, input logic we, input logic [1:0] size,
                        input logic [23:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata);
    int n;
    n = 0;
    while (((s ? ready_b : ready_a) !== 1'b1) && n < 2000) begin tick(); n++; end
    req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    if (s) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    tick();
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    lat = 1;
    while (((s ? rsp_valid_b : rsp_valid_a) !== 1'b1) && lat < 2000) begin tick(); lat++; end
    rdata = s ? rdata_b : rdata_a;
  endtask

  task automatic test_reset();
    reset_a = 1'b0; reset_b = 1'b0;
    tick(); tick();
    n_checks++;
    if ({sclk_a, ce_a, si_a, ready_a, rsp_valid_a, busy_a} !== 6'b010000)
      $display("FAIL reset_pins_a: got %b expected %b", {sclk_a, ce_a, si_a, ready_a, rsp_valid_a, busy_a}, 6'b010000);
    else n_pass++;
    n_checks++;
    if (rdata_a !== 32'h0) $display("FAIL reset_rdata_a: got %h expected %h", rdata_a, 32'h0);
    else n_pass++;
    n_checks++;
    if ({sclk_b, ce_b, si_b, ready_b, rsp_valid_b, busy_b} !== 6'b010000)
      $display("FAIL reset_pins_b: got %b expected %b", {sclk_b, ce_b, si_b, ready_b, rsp_valid_b, busy_b}, 6'b010000);
    else n_pass++;
  endtask

  task automatic test_init();
    int r0, n;
    logic saw_rsp, saw_busy, prev_ce;
    r0 = m_rises; n = 0; saw_rsp = 1'b0; saw_busy = 1'b0; prev_ce = ce_a;
    reset_a = 1'b1;
    while (ready_a !== 1'b1 && n < 500) begin
      prev_ce = ce_a;
      tick(); n++;
      if (rsp_valid_a) saw_rsp = 1'b1;
      if (busy_a) saw_busy = 1'b1;
    end
    n_checks++;
    if (ready_a !== 1'b1) $display("FAIL init_ready: got %b expected %b", ready_a, 1'b1); else n_pass++;
    n_checks++;
    if (m_rises - r0 !== 16) $display("FAIL init_edges: got %0d expected %0d", m_rises - r0, 16); else n_pass++;
    n_checks++;
    if (m_frame16 !== 16'h0140) $display("FAIL init_frame: got %h expected %h", m_frame16, 16'h0140); else n_pass++;
    n_checks++;
    if (m_mode !== 8'h40) $display("FAIL init_mode: got %h expected %h", m_mode, 8'h40); else n_pass++;
    n_checks++;
    if ({saw_rsp, saw_busy, prev_ce} !== 3'b011)
      $display("FAIL init_flags: got rsp/busy/ce_before_ready=%b expected %b", {saw_rsp, saw_busy, prev_ce}, 3'b011);
    else n_pass++;
  endtask

  task automatic test_write_word();
    int r0, lat;
    logic [31:0] rd;
    r0 = m_rises;
    do_req(1'b0, 1'b1, 2'b10, 24'h000100, 32'hDEADBEEF, lat, rd);
    n_checks++;
    if (lat !== 261) $display("FAIL wr_word_lat: got %0d expected %0d", lat, 261); else n_pass++;
    n_checks++;
    if (m_rises - r0 !== 64) $display("FAIL wr_word_edges: got %0d expected %0d", m_rises - r0, 64); else n_pass++;
    n_checks++;
    if ({mem[16'h0103], mem[16'h0102], mem[16'h0101], mem[16'h0100]} !== 32'hDEADBEEF)
      $display("FAIL wr_word_mem: got %h expected %h",
               {mem[16'h0103], mem[16'h0102], mem[16'h0101], mem[16'h0100]}, 32'hDEADBEEF);
    else n_pass++;
    n_checks++;
    if ({busy_a, ready_a, ce_a} !== 3'b101)
      $display("FAIL done_pins: got busy/ready/ce=%b expected %b", {busy_a, ready_a, ce_a}, 3'b101);
    else n_pass++;
    tick();
    n_checks++;
    if ({busy_a, ready_a, rsp_valid_a} !== 3'b010)
      $display("FAIL after_done: got busy/ready/rsp=%b expected %b", {busy_a, ready_a, rsp_valid_a}, 3'b010);
    else n_pass++;
  endtask

  task automatic test_read_sizes();
    logic [1:0]  sz [5] = '{2'b10, 2'b01, 2'b00, 2'b11, 2'b01};
    logic [23:0] ad [5] = '{24'h000100, 24'h000100, 24'h000100, 24'h000100, 24'h000102};
    logic [31:0] ex [5] = '{32'hDEADBEEF, 32'h0000BEEF, 32'h000000EF, 32'hDEADBEEF, 32'h0000DEAD};
    int          el [5] = '{261, 197, 165, 261, 197};
    int lat;
    logic [31:0] rd;
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, 1'b0, sz[i], ad[i], 32'hFFFFFFFF, lat, rd);
      n_checks++;
      if (rd !== ex[i]) $display("FAIL rd_data[%0d]: got %h expected %h", i, rd, ex[i]); else n_pass++;
      n_checks++;
      if (lat !== el[i]) $display("FAIL rd_lat[%0d]: got %0d expected %0d", i, lat, el[i]); else n_pass++;
    end
    do_req(1'b0, 1'b1, 2'b00, 24'h000200, 32'h00000077, lat, rd);
    n_checks++;
    if (rd !== 32'h0000DEAD) $display("FAIL rdata_hold: got %h expected %h", rd, 32'h0000DEAD); else n_pass++;
    n_checks++;
    if (mem[16'h0200] !== 8'h77) $display("FAIL wr_byte_mem: got %h expected %h", mem[16'h0200], 8'h77); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int a1, a2, r1, r2, bad, extra, n;
    logic [31:0] rd2;
    a1 = -1; a2 = -1; r1 = -1; r2 = -1; bad = 0; extra = 0; n = 0; rd2 = 32'h0;
    while (ready_a !== 1'b1 && n < 2000) begin tick(); n++; end
    req_we = 1'b1; req_size = 2'b00; req_addr = 24'h000300; req_wdata = 32'h00000011;
    req_valid_a = 1'b1;
    for (int cyc = 0; cyc < 800 && r2 < 0; cyc++) begin
      if (req_valid_a && ready_a) begin
        if (a1 < 0) a1 = cyc; else if (a2 < 0) a2 = cyc; else extra++;
      end
      if (busy_a && ready_a) bad++;
      if (rsp_valid_a) begin
        if (r1 < 0) r1 = cyc;
        else begin r2 = cyc; rd2 = rdata_a; req_valid_a = 1'b0; end
      end
      if (cyc == 1) req_we = 1'b0;
      tick();
    end
    req_valid_a = 1'b0;
    n_checks++;
    if ({a1, r1, a2, r2} !== {32'sd0, 32'sd165, 32'sd166, 32'sd331})
      $display("FAIL b2b_timing: got acc1=%0d rsp1=%0d acc2=%0d rsp2=%0d expected 0 165 166 331", a1, r1, a2, r2);
    else n_pass++;
    n_checks++;
    if ({bad, extra} !== 64'd0) $display("FAIL b2b_ignored: got busy&ready=%0d extra=%0d expected 0 0", bad, extra);
    else n_pass++;
    n_checks++;
    if (rd2 !== 32'h00000011) $display("FAIL b2b_rdata: got %h expected %h", rd2, 32'h00000011); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int r0, n, lat;
    logic [31:0] rd;
    n = 0;
    while (ready_a !== 1'b1 && n < 2000) begin tick(); n++; end
    r0 = m_rises;
    req_we = 1'b1; req_size = 2'b10; req_addr = 24'h000100; req_wdata = 32'h12345678;
    req_valid_a = 1'b1;
    tick();
    req_valid_a = 1'b0;
    n = 0;
    while ((m_rises - r0) < 20 && n < 1000) begin tick(); n++; end
    n_checks++;
    if (m_rises - r0 !== 20) $display("FAIL mid_bits: got %0d expected %0d", m_rises - r0, 20); else n_pass++;
    reset_a = 1'b0;
    #1;
    n_checks++;
    if ({ce_a, sclk_a, busy_a, ready_a, rsp_valid_a} !== 5'b10000)
      $display("FAIL mid_reset_pins: got ce/sclk/busy/ready/rsp=%b expected %b",
               {ce_a, sclk_a, busy_a, ready_a, rsp_valid_a}, 5'b10000);
    else n_pass++;
    tick(); tick();
    r0 = m_rises;
    reset_a = 1'b1;
    n = 0;
    while (ready_a !== 1'b1 && n < 500) begin tick(); n++; end
    n_checks++;
    if (m_rises - r0 !== 16 || m_frame16 !== 16'h0140)
      $display("FAIL mid_reinit: got edges=%0d frame=%h expected 16 0140", m_rises - r0, m_frame16);
    else n_pass++;
    do_req(1'b0, 1'b0, 2'b10, 24'h000100, 32'h0, lat, rd);
    n_checks++;
    if (rd !== 32'hDEADBEEF || lat !== 261)
      $display("FAIL mid_readback: got %h lat %0d expected deadbeef lat 261", rd, lat);
    else n_pass++;
  endtask

  task automatic test_div_aw();
    int r0, n, lat;
    logic [31:0] rd, exp_w;
    logic [7:0] old_next;
    sel = 1'b1;
    r0 = m_rises;
    reset_b = 1'b1;
    n = 0;
    while (ready_b !== 1'b1 && n < 500) begin tick(); n++; end
    n_checks++;
    if (m_rises - r0 !== 16 || m_frame16 !== 16'h0140)
      $display("FAIL b_init: got edges=%0d frame=%h expected 16 0140", m_rises - r0, m_frame16);
    else n_pass++;
    old_next = mem[16'h1235];
    r0 = m_rises;
    do_req(1'b1, 1'b1, 2'b00, 24'h001234, 32'hFFFFFF5A, lat, rd);
    n_checks++;
    if (lat !== 67) $display("FAIL b_wr_lat: got %0d expected %0d", lat, 67); else n_pass++;
    n_checks++;
    if (m_rises - r0 !== 32) $display("FAIL b_wr_edges: got %0d expected %0d", m_rises - r0, 32); else n_pass++;
    n_checks++;
    if (mem[16'h1234] !== 8'h5A || mem[16'h1235] !== old_next)
      $display("FAIL b_wr_mem: got %h %h expected 5a %h", mem[16'h1234], mem[16'h1235], old_next);
    else n_pass++;
    do_req(1'b1, 1'b0, 2'b00, 24'h001234, 32'h0, lat, rd);
    n_checks++;
    if (rd !== 32'h0000005A || lat !== 67)
      $display("FAIL b_rd_byte: got %h lat %0d expected 0000005a lat 67", rd, lat);
    else n_pass++;
    exp_w = {mem[16'h1237], mem[16'h1236], mem[16'h1235], 8'h5A};
    do_req(1'b1, 1'b0, 2'b10, 24'h001234, 32'h0, lat, rd);
    n_checks++;
    if (rd !== exp_w || lat !== 115)
      $display("FAIL b_rd_word: got %h lat %0d expected %h lat 115", rd, lat, exp_w);
    else n_pass++;
  endtask

  initial begin
    reset_a = 1'b0; reset_b = 1'b0; sel = 1'b0;
    req_valid_a = 1'b0; req_valid_b = 1'b0; req_we = 1'b0;
    req_size = 2'b00; req_addr = 24'h0; req_wdata = 32'h0;
    test_reset();
    test_init();
    test_write_word();
    test_read_sizes();
    test_back_to_back();
    test_reset_mid();
    test_div_aw();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_sram_ctrl.md
# spi_sram_ctrl

Parametrised SPI master that turns single CPU memory requests into serial-SRAM transactions. It replaces the fixed byte-wide SPI path between `cpu` and the external SRAM (`so`/`si`/`sclk`/`sram_ce`). It adds:
- a configurable address width and SCLK divider;
- byte, halfword and word accesses;
- an optional post-reset mode-register write that puts the SRAM into sequential mode.

It sits between the core's load/store unit and the SRAM pins. It runs on the core clock.

## Interface
Parameters:
- `ADDR_W`, 24: SRAM address bits sent per transaction. Legal values are 16 or 24; the value must be a multiple of 8.
- `CLK_DIV`, 2: SCLK half-period in `clk` cycles. Must be ≥1.
- `INIT_MODE`, 1: when 1, the block issues WRMR (0x01, 0x40) once after reset.

Ports:
- `clk`: in, 1. Core clock.
- `reset`: in, 1. Asynchronous, active-low reset.
- `req_valid`: in, 1. Request strobe.
- `req_ready`: out, 1. The block accepts a request when `req_valid && req_ready`.
- `req_we`: in, 1. 1 = write, 0 = read.
- `req_size`: in, 2. 00 = byte, 01 = halfword, 10 and 11 = word.
- `req_addr`: in, `ADDR_W`. Byte address.
- `req_wdata`: in, 32. Write data; only the low 8×nbytes bits are used.
- `rsp_valid`: out, 1. One-cycle completion pulse.
- `rsp_rdata`: out, 32. Read data, zero-extended. Holds its value until the next read completes.
- `busy`: out, 1. High from request accept or init start until `rsp_valid` (or init end), inclusive.
- `sclk`: out, 1. SPI clock, mode 0 (idles low).
- `sram_ce`: out, 1. Chip enable, active-low.
- `si`: out, 1. Master out, connects to the SRAM's SI pin.
- `so`: in, 1. Master in, driven by the SRAM's SO pin.

## Operation
- **States:** RESET_INIT, IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE.
- **Reset values** (while `reset` is low): `sclk`=0, `sram_ce`=1, `si`=0, `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `busy`=0.
  - After release, state is RESET_INIT if `INIT_MODE`=1, otherwise IDLE.
- **RESET_INIT:** loads the 16-bit frame 0x01,0x40 and enters CS_SETUP. `busy`=1. It does not end with `rsp_valid`; the block returns to IDLE afterwards.
- **IDLE:** `req_ready`=1. On accept, the block latches `we`, `size`, `addr`, `wdata` and `nbytes` (1/2/4), then goes to CS_SETUP. Outside IDLE, `req_ready`=0 and `req_valid` is ignored.
- **Frame sent on `si`:** command byte (0x03 read, 0x02 write), then `addr` MSB-first, then data.
  - **Write data:** byte0 = `wdata[7:0]` at `addr`, byte1 at `addr+1`, and so on. Each byte is sent MSB-first.
  - **Read data:** captured little-endian in the same order. During read data bits, `si` holds 0.
- **Bit count:** N = 8 + `ADDR_W` + 8·nbytes. For the init frame, N = 16.
- **CS_SETUP:** `sram_ce`=0 and `sclk`=0 for `CLK_DIV` cycles; the first bit is already on `si`.
- **SHIFT:** for each bit, `sclk` is low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
  - `si` changes only on the cycle `sclk` falls (or at CS_SETUP entry for bit 0).
  - `so` is sampled on the `clk` edge at which `sclk` rises.
- **CS_HOLD:** after the last high phase, `sclk`=0 and `sram_ce`=0 for `CLK_DIV` cycles.
- **DONE:** one cycle.
  - `sram_ce`=1 and `rsp_valid`=1 (suppressed for init).
  - For reads, `rsp_rdata` updates in this same cycle.
  - Next state is IDLE, so `req_ready` rises the following cycle.
- **Addressing:** no alignment check. The SRAM handles address wrap at the top of the array in sequential mode; the block never modifies `addr`.
- **Reset mid-transaction:** all outputs return to their reset values asynchronously. The partial SRAM access is abandoned, and a new init runs if `INIT_MODE`=1.

## Timing
- **Accept to `rsp_valid`:** 1 + `CLK_DIV` + 2·`CLK_DIV`·N + `CLK_DIV` cycles. The accept cycle is cycle 0; `rsp_valid` is in the last counted cycle.
- **Back-to-back requests:** minimum accept spacing is the latency above + 1. `sram_ce` is high for at least 2 cycles between frames (DONE plus the IDLE accept cycle).
- **Init:** starts the first `clk` edge after `reset` deasserts. `req_ready` first rises 1 + 1 + `CLK_DIV` + 32·`CLK_DIV` + `CLK_DIV` + 1 cycles after release.
- **Combinational paths:** none from inputs to outputs. All outputs are registered.

## Test plan
- **Init frame:** `CLK_DIV`=2, `INIT_MODE`=1, behavioural SRAM model attached, release reset.
  - Required: exactly 16 SCLK rising edges, with `si` sampled as 0x01 then 0x40.
  - Required: `sram_ce` high again before `req_ready` rises, and no `rsp_valid`.
- **Word write:** write word, `addr`=0x000100, `wdata`=0xDEADBEEF.
  - Required: 64 SCLK edges, and the model holds 0xEF, 0xBE, 0xAD, 0xDE at 0x100–0x103.
  - Required: `rsp_valid` exactly 261 cycles after accept.
- **Read-back with sizes:** word, halfword and byte reads at 0x100.
  - Required: `rsp_rdata` = 0xDEADBEEF, 0x0000BEEF, 0x000000EF.
  - Required: latencies 261, 197, 165 cycles.
- **Ignored requests and spacing:** hold `req_valid` high continuously across two transactions.
  - Required: the second accept happens exactly one cycle after the first `rsp_valid`, and nothing is accepted while `busy`.
- **Reset mid-SHIFT:** assert `reset` at bit 20 of a write.
  - Required: `sram_ce`=1, `sclk`=0 and `busy`=0 immediately.
  - Required: after release, the init frame repeats, and a subsequent read returns the model's pre-existing contents.
- **Divider and address width:** `CLK_DIV`=1, `ADDR_W`=16, byte write 0x5A at 0x1234.
  - Required: N=32, latency 67 cycles, model byte 0x1234 = 0x5A.
